imem_ctrl: RTL and testbench

Sequencing controller for the CPU instruction memory. After reset it zeroes every word, streams a program image from a loader port into consecutive words starting at `BASE_ADDR`, then switches to run mode. In run mode it serves registered instruction fetches to the CPU with PC translation, alignment and range checks. It owns the only write port of the instruction RAM and sits between the boot loader, the fetch stage and the RAM.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_addr_chk.sv | 27 ++
 rtl/imem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_imem_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory controller.
//   - state_t          : controller sequencing states (CLEAR / LOAD / RUN)
//   - BASE_ADDR_DEF    : default byte address of memory word 0
//   - MEM_BYTES_DEF    : default memory size in bytes
//   - DEPTH_DEF        : default depth in 32-bit words
//   - ADDR_W_DEF       : default word-address width
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_3000;
  localparam int          MEM_BYTES_DEF = 'h1000;
  localparam int          DEPTH_DEF     = MEM_BYTES_DEF / 4;
  localparam int          ADDR_W_DEF    = $clog2(DEPTH_DEF);

endpackage

// File: rtl/imem_addr_chk.sv
// imem_addr_chk: combinational byte-PC to word-address translation with
// alignment and range checking. Shared with the data-memory controller.
// Ports:
//   pc        in   32      byte address from the requester
//   word_addr out  ADDR_W  word index into the memory (valid when !fault)
//   fault     out  1       misaligned PC or PC outside [BASE_ADDR, BASE_ADDR+MEM_BYTES)
module imem_addr_chk #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          MEM_BYTES = 'h1000,
  parameter int          ADDR_W    = 10
) (
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] word_addr,
  output logic              fault
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [31:0] off;

  // A PC below the base wraps to a huge offset, so a single unsigned
  // compare covers both ends of the window.
  assign off       = pc - BASE_ADDR;
  assign word_addr = off[ADDR_W+1:2];
  assign fault     = (off[1:0] != 2'b00) || (off >= MEM_LIMIT);

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction-memory sequencing controller. Zeroes the RAM after
// reset, streams a boot image from the loader into consecutive words, then
// serves registered instruction fetches to the CPU.
// Ports:
//   clock, reset              clock; asynchronous active-low reset
//   reload                    pulse in RUN restarts CLEAR -> LOAD
//   load_valid/data/last      loader word stream; load_ready accepts it
//   load_overflow             sticky: image longer than DEPTH words
//   fetch_req/fetch_pc        CPU fetch request; fetch_ready accepts it
//   fetch_valid/instr/fault   registered one-cycle fetch response
//   cpu_run                   high while in RUN
//   mem_we/addr/wdata/rdata   single port of the external RAM
module imem_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          MEM_BYTES = MEM_BYTES_DEF,
  parameter int          ADDR_W    = $clog2(MEM_BYTES / 4),
  parameter int          DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reload,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_overflow,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  output logic              cpu_run,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int             DEPTH     = MEM_BYTES / 4;
  localparam logic [ADDR_W:0] DEPTH_P  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_WORD = DEPTH_P - 1'b1;

  state_t            state;
  state_t            state_nxt;
  // One extra bit so the load pointer can sit at DEPTH once the RAM is full.
  logic [ADDR_W:0]   ptr;
  logic              ptr_in_range;
  logic              load_acc;
  logic              fetch_acc;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_fault;

  logic              vld_p1;
  logic [DATA_W-1:0] instr_p1;
  logic              fault_p1;

  imem_addr_chk #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_addr_chk (
    .pc        (fetch_pc),
    .word_addr (chk_addr),
    .fault     (chk_fault)
  );

  assign ptr_in_range = (ptr < DEPTH_P);
  assign load_acc     = (state == ST_LOAD) && load_valid;
  assign fetch_acc    = (state == ST_RUN) && fetch_req;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (ptr == LAST_WORD)        state_nxt = ST_LOAD;
      ST_LOAD:  if (load_valid && load_last) state_nxt = ST_RUN;
      ST_RUN:   if (reload)                  state_nxt = ST_CLEAR;
      default:                               state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode: RAM port and handshakes
  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = ptr[ADDR_W-1:0];
    mem_wdata   = '0;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      ST_CLEAR: begin
        mem_we = 1'b1;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid && ptr_in_range;
        mem_wdata  = load_data;
      end
      ST_RUN: begin
        fetch_ready = fetch_req;
        mem_addr    = chk_addr;
      end
      default: ;
    endcase
  end

  // Write pointer and overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr           <= '0;
      load_overflow <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: ptr <= (ptr == LAST_WORD) ? '0 : ptr + 1'b1;
        ST_LOAD: begin
          if (load_acc && ptr_in_range) ptr <= ptr + 1'b1;
          if (load_acc && !ptr_in_range) load_overflow <= 1'b1;
        end
        ST_RUN: begin
          if (reload) begin
            ptr           <= '0;
            load_overflow <= 1'b0;
          end
        end
        default: ptr <= '0;
      endcase
    end
  end

  // ---- stage p0 -> p1: registered fetch response ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      fault_p1 <= 1'b0;
      cpu_run  <= 1'b0;
    end else begin
      vld_p1  <= fetch_acc;
      cpu_run <= (state_nxt == ST_RUN);
      if (fetch_acc) begin
        instr_p1 <= chk_fault ? '0 : mem_rdata;
        fault_p1 <= chk_fault;
      end else begin
        fault_p1 <= 1'b0;
      end
    end
  end

  assign fetch_valid = vld_p1;
  assign fetch_instr = instr_p1;
  assign fetch_fault = fault_p1;

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reload = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_overflow;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        cpu_run;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  imem_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .reload        (reload),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .load_overflow (load_overflow),
    .fetch_req     (fetch_req),
    .fetch_pc      (fetch_pc),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_fault   (fetch_fault),
    .cpu_run       (cpu_run),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural RAM outside the controller, pre-filled with garbage.
  logic [31:0] ram [0:1023];
  initial for (int k = 0; k < 1024; k++) ram[k] = 32'hDEAD_BEEF;
  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          at_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clock) begin
    if (reset && fetch_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_instr", fetch_instr, e.instr);
        chk("resp_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
        chk("resp_cycle", cyc, e.at_cyc);
      end
    end
  end

  // Called at a negedge with the controller in CLEAR at ptr 0.
  task automatic clear_check(input string tag);
    int errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!(mem_we === 1'b1 && mem_addr === 10'(i) && mem_wdata === 32'd0 &&
            load_ready === 1'b0 && cpu_run === 1'b0 && fetch_ready === 1'b0))
        errs++;
      @(negedge clock);
    end
    chk({tag, "_clear_seq"}, errs, 0);
    chk({tag, "_load_ready"}, {31'd0, load_ready}, 32'd1);
    chk({tag, "_load_no_we"}, {31'd0, mem_we}, 32'd0);
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(negedge clock);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    exp_t e;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    e.instr   = ei;
    e.fault   = ef;
    e.at_cyc  = cyc + 1;
    exp_q.push_back(e);
    #1 chk("fetch_ready", {31'd0, fetch_ready}, 32'd1);
    @(negedge clock);
    fetch_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held low.
    repeat (3) @(negedge clock);
    chk("rst_cpu_run",     {31'd0, cpu_run},       32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid},   32'd0);
    chk("rst_fetch_instr", fetch_instr,            32'd0);
    chk("rst_fetch_fault", {31'd0, fetch_fault},   32'd0);
    chk("rst_overflow",    {31'd0, load_overflow}, 32'd0);
    chk("rst_load_ready",  {31'd0, load_ready},    32'd0);
    reset = 1'b1;
    clear_check("boot");
    chk("ram_cleared_mid", ram[500], 32'd0);

    // Three-word image, back to back, last on the third.
    load_valid = 1'b1; load_data = 32'h2008_0005; @(negedge clock);
    load_data = 32'h2009_0003; @(negedge clock);
    load_data = 32'h0109_5020; load_last = 1'b1; @(negedge clock);
    load_valid = 1'b0; load_last = 1'b0;
    chk("cpu_run_after_last", {31'd0, cpu_run}, 32'd1);
    chk("load_ready_in_run",  {31'd0, load_ready}, 32'd0);
    chk("ram0", ram[0], 32'h2008_0005);
    chk("ram1", ram[1], 32'h2009_0003);
    chk("ram2", ram[2], 32'h0109_5020);

    fetch(32'h0000_3004, 32'h2009_0003, 1'b0);
    @(negedge clock);
    fetch_req = 1'b1;  // back-to-back pair
    fetch(32'h0000_3000, 32'h2008_0005, 1'b0);
    fetch_req = 1'b1;
    fetch(32'h0000_3008, 32'h0109_5020, 1'b0);
    fetch(32'h0000_3002, 32'h0, 1'b1);
    fetch(32'h0000_4000, 32'h0, 1'b1);
    fetch(32'h0000_2FFC, 32'h0, 1'b1);
    fetch(32'h0000_3FFC, 32'h0, 1'b0);
    @(negedge clock);

    // Reload with a fetch in the same cycle.
    reload = 1'b1;
    fetch(32'h0000_3008, 32'h0109_5020, 1'b0);
    reload = 1'b0;
    chk("reload_cpu_run", {31'd0, cpu_run}, 32'd0);
    clear_check("reload1");

    // Overflowing image: 1025 words, last on the 1025th.
    begin
      int we_errs = 0;
      for (int i = 0; i < 1025; i++) begin
        load_valid = 1'b1;
        load_data  = 32'hA500_0000 + i;
        load_last  = (i == 1024);
        #1 if (mem_we !== (i < 1024)) we_errs++;
        @(negedge clock);
      end
      load_valid = 1'b0; load_last = 1'b0;
      chk("ovf_we_pattern", we_errs, 0);
    end
    chk("ovf_flag",    {31'd0, load_overflow}, 32'd1);
    chk("ovf_cpu_run", {31'd0, cpu_run},       32'd1);
    chk("ovf_ram0",    ram[0],    32'hA500_0000);
    chk("ovf_ram1023", ram[1023], 32'hA500_03FF);
    fetch(32'h0000_3FFC, 32'hA500_03FF, 1'b0);
    fetch(32'h0000_3010, 32'hA500_0004, 1'b0);

    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    chk("reload2_cpu_run",  {31'd0, cpu_run},       32'd0);
    chk("reload2_overflow", {31'd0, load_overflow}, 32'd0);
    clear_check("reload2");

    // Reset in the middle of a load.
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    chk("partial_ram1", ram[1], 32'h2222_2222);
    load_valid = 1'b1; load_data = 32'h3333_3333;
    reset = 1'b0;
    #1;
    chk("midrst_cpu_run",    {31'd0, cpu_run},       32'd0);
    chk("midrst_load_ready", {31'd0, load_ready},    32'd0);
    chk("midrst_overflow",   {31'd0, load_overflow}, 32'd0);
    chk("midrst_valid",      {31'd0, fetch_valid},   32'd0);
    chk("midrst_mem_addr",   {22'd0, mem_addr},      32'd0);
    load_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_check("midrst");
    chk("midrst_ram0", ram[0], 32'd0);
    chk("midrst_ram1", ram[1], 32'd0);

    repeat (4) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
